// File: rtl/rx_buf_pkg.sv
// Shared constants, state encoding and ring helpers
// for the MAC RX buffer write side.
package rx_buf_pkg;

   localparam int DEPTH   = 768;
   localparam int AW      = 10;
   localparam int MAX_LEN = 1522;
   localparam int CNT_W   = 16;
   localparam int LEN_LSB = 0;
   localparam int LEN_W   = 16;

   typedef enum logic [2:0] {
      IDLE,
      DATA,
      HDR,
      DROP,
      REWIND
   } state_e;

   function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

endpackage

// File: rtl/rx_byte_packer.sv
// Packs a byte stream little-endian into 32-bit words;
// fires on the 4th byte or on the frame's last byte.
module rx_byte_packer (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        en,
   input  logic        eof,
   input  logic [7:0]  din,
   output logic        fire,
   output logic [31:0] word
);

   logic [1:0]  lane_q, lane_d, lane_b;
   logic [31:0] word_q, word_d, word_b;

   always_comb begin
      lane_b = clr ? 2'd0 : lane_q;
      word_b = clr ? 32'h0 : word_q;
      word = word_b;
      word[{lane_b, 3'b000} +: 8] = din;
      fire = en & ((lane_b == 2'd3) | eof);
      lane_d = lane_q;
      word_d = word_q;
      if (en) begin
         // a fired word restarts from zero so flushed lanes read as 0
         lane_d = fire ? 2'd0 : lane_b + 2'd1;
         word_d = fire ? 32'h0 : word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lane_q <= '0;
         word_q <= '0;
      end else begin
         lane_q <= lane_d;
         word_q <= word_d;
      end
   end

endmodule

// File: rtl/rx_frame_writer.sv
// RX buffer write front end: frames go into the ring as a
// header word plus data words, committed only when good.
module rx_frame_writer
   import rx_buf_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             rx_dv,
   input  logic [7:0]       rx_data,
   input  logic             rx_sof,
   input  logic             rx_eof,
   input  logic             rx_err,
   input  logic [AW-1:0]    rd_ptr,
   output logic             cew,
   output logic [AW-1:0]    aw,
   output logic [31:0]      dw,
   output logic [AW-1:0]    wr_ptr,
   output logic             frame_done,
   output logic             frame_drop,
   output logic [CNT_W-1:0] drop_cnt
);

   state_e state_q, state_d;

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    hdr_q, hdr_d;
   logic [AW-1:0]    dptr_q, dptr_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             cew_q, cew_d;
   logic [AW-1:0]    aw_q, aw_d;
   logic [31:0]      dw_q, dw_d;
   logic             done_q, done_d;
   logic             drop_q, drop_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             start, byte_in, fire;
   logic             hdr_ok, wr_ok, too_long, bad;
   logic [AW-1:0]    dptr_b;
   logic [LEN_W-1:0] len_b, len_n;
   logic [31:0]      pk_word;

   // a sof in DATA restarts the frame exactly as from IDLE
   assign start   = rx_dv & rx_sof &
                    ((state_q == IDLE) | (state_q == DATA));
   assign byte_in = rx_dv & (start | (state_q == DATA));

   assign dptr_b   = start ? next_ptr(wr_ptr_q) : dptr_q;
   assign len_b    = start ? '0 : len_q;
   assign len_n    = len_b + 1'b1;
   assign hdr_ok   = ~start | (next_ptr(wr_ptr_q) != rd_ptr);
   assign wr_ok    = next_ptr(dptr_b) != rd_ptr;
   assign too_long = len_n > LEN_W'(MAX_LEN);
   assign bad      = ~hdr_ok | (fire & ~wr_ok) | too_long;

   rx_byte_packer u_packer (
      .clk  (clk),
      .rst  (rst),
      .clr  (start),
      .en   (byte_in),
      .eof  (rx_eof),
      .din  (rx_data),
      .fire (fire),
      .word (pk_word)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, DATA: begin
            if (byte_in) begin
               if (rx_eof) state_d = (bad | rx_err) ? REWIND : HDR;
               else        state_d = bad ? DROP : DATA;
            end
         end
         HDR:     state_d = IDLE;
         DROP:    if (rx_dv & rx_eof) state_d = REWIND;
         REWIND:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      hdr_d    = hdr_q;
      dptr_d   = dptr_q;
      len_d    = len_q;
      cew_d    = 1'b0;
      aw_d     = aw_q;
      dw_d     = dw_q;
      done_d   = 1'b0;
      cnt_d    = cnt_q;
      if (start) hdr_d = wr_ptr_q;
      if (byte_in) begin
         len_d  = len_n;
         dptr_d = fire ? next_ptr(dptr_b) : dptr_b;
         if (fire & wr_ok & hdr_ok) begin
            cew_d = 1'b1;
            aw_d  = dptr_b;
            dw_d  = pk_word;
         end
      end
      if (state_q == HDR) begin
         cew_d = 1'b1;
         aw_d  = hdr_q;
         dw_d  = '0;
         dw_d[LEN_LSB +: LEN_W] = len_q;
         wr_ptr_d = dptr_q;
         done_d   = 1'b1;
      end
      drop_d = (state_q == REWIND) | ((state_q == DATA) & start);
      if (drop_d && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         hdr_q    <= '0;
         dptr_q   <= '0;
         len_q    <= '0;
         cew_q    <= 1'b0;
         aw_q     <= '0;
         dw_q     <= '0;
         done_q   <= 1'b0;
         drop_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         hdr_q    <= hdr_d;
         dptr_q   <= dptr_d;
         len_q    <= len_d;
         cew_q    <= cew_d;
         aw_q     <= aw_d;
         dw_q     <= dw_d;
         done_q   <= done_d;
         drop_q   <= drop_d;
         cnt_q    <= cnt_d;
      end
   end

   assign cew        = cew_q;
   assign aw         = aw_q;
   assign dw         = dw_q;
   assign wr_ptr     = wr_ptr_q;
   assign frame_done = done_q;
   assign frame_drop = drop_q;
   assign drop_cnt   = cnt_q;

endmodule

// File: doc/rx_frame_writer.md
Name: rx_frame_writer

Overview:
- Write-side front end of the Ethernet MAC RX buffer.
- Accepts the MAC RX byte stream, packs bytes little-endian into 32-bit words and writes them into the 768x32 RX dual-port RAM, which it uses as a ring.
- Each frame is stored as one header word followed by its data words.
- Only complete, error-free frames that fit are committed to the consumer via wr_ptr. Errored, oversize and overflowing frames are rewound and counted.

Parameters:
- DEPTH, 768, ring depth in 32-bit words; addresses 0..DEPTH-1.
- AW, 10, RAM address width.
- MAX_LEN, 1522, maximum accepted frame length in bytes.
- CNT_W, 16, drop counter width.

Ports:
- clk  in  1  single clock; also drives the RAM write port.
- rst  in  1  synchronous, active-high reset.
- rx_dv  in  1  byte valid qualifier; at most one byte per cycle.
- rx_data  in  8  frame byte.
- rx_sof  in  1  marks the first byte of a frame; qualified by rx_dv.
- rx_eof  in  1  marks the last byte of a frame; qualified by rx_dv.
- rx_err  in  1  frame error (CRC/PHY); sampled with the rx_eof byte.
- rd_ptr  in  AW  consumer read pointer: the first word not yet released.
- cew  out  1  RAM write enable.
- aw  out  AW  RAM write address.
- dw  out  32  RAM write data.
- wr_ptr  out  AW  committed write pointer; the ring is empty when wr_ptr == rd_ptr.
- frame_done  out  1  1-cycle pulse when a frame is committed.
- frame_drop  out  1  1-cycle pulse when a frame is discarded.
- drop_cnt  out  CNT_W  dropped-frame count; saturates at all-ones.

Behaviour:
- Reset: all outputs are 0, the state is IDLE and internal pointers are 0. The consumer must be reset together with this block.
- Pointer advance: next(p) = (p == DEPTH-1) ? 0 : p+1.
- Write permission: a write to address a is allowed only if next(a) != rd_ptr. One slot always stays empty.
- All RAM outputs (cew/aw/dw) are registered. A write is issued in the cycle after the byte that completes its word.

State machine:
- IDLE
  - rx_dv & rx_sof: hdr_addr = wr_ptr, dptr = next(wr_ptr), lane = 0, len = 0.
  - If the header slot is not writable, go to DROP; otherwise go to DATA.
  - The sof byte is packed as lane 0.
  - rx_dv without rx_sof is ignored.
- DATA
  - Each rx_dv byte goes to dw[8*lane+:8]; len increments.
  - When lane 3 is filled, write the word at dptr and advance dptr.
  - If the write is not allowed, go to DROP.
  - len > MAX_LEN: go to DROP.
- DATA end of frame (rx_eof)
  - A partial word is written with unused lanes zero.
  - rx_err = 1: go to REWIND; otherwise go to HDR.
- DATA, rx_sof arrives mid-frame: the current frame is dropped (frame_drop pulse, drop_cnt increments), and the new frame starts in the same cycle as if from IDLE.
- HDR: one cycle.
  - Writes {16'h0, len[15:0]} at hdr_addr.
  - The next cycle sets wr_ptr = dptr, pulses frame_done, and returns to IDLE.
  - A byte arriving during HDR is ignored. The upstream inter-frame gap of at least 2 cycles is a requirement.
- DROP: discard bytes until rx_eof, then go to REWIND.
- REWIND: wr_ptr is unchanged, pulse frame_drop, drop_cnt increments, go to IDLE.
- Data written during a dropped frame is harmless; the slots lie beyond wr_ptr.
- len is 16 bits. A zero-length frame cannot occur; sof and eof on the same byte gives len = 1.
- rd_ptr may change on any cycle; the permission check uses its current value.
- Reset mid-frame abandons the frame immediately, with no pulses.

Decomposition:
- Shared package rx_buf_pkg:
  - DEPTH, AW, MAX_LEN constants.
  - Header field positions (LEN_LSB = 0, LEN_W = 16).
  - State enum {IDLE, DATA, HDR, DROP, REWIND}.
  - next_ptr function.
- One natural sub-module: rx_byte_packer, which handles lane counting, word assembly and the flush on eof.

Test Plan:
- Empty ring (rd_ptr = 0), 5-byte frame 01..05 → writes: aw = 1 dw = 0x04030201; aw = 2 dw = 0x00000005; aw = 0 dw = 0x00000005. Then wr_ptr = 3, frame_done pulses once.
- wr_ptr = rd_ptr = 766, 8-byte frame 11..18 → data at 767 = 0x14131211 and at 0 = 0x18171615; header at 766 = 0x00000008; wr_ptr = 1 (wrap-around).
- rd_ptr = 5, wr_ptr = 0, 20-byte frame (needs 6 words) → frame_drop, drop_cnt = 1, wr_ptr stays 0. A following 8-byte frame commits with wr_ptr = 3.
- 64-byte frame with rx_err on the eof byte → frame_drop, no frame_done, wr_ptr unchanged.
- 1600-byte frame → drop at byte 1523, remaining bytes discarded, drop_cnt increments.
- Frame A (10 bytes, no eof) followed by sof of frame B (4 bytes) → A is dropped; B header at A's hdr_addr with len = 4, wr_ptr advances by 2.
- Reset asserted mid-frame → all outputs 0 the next cycle, no pulses.
